// File: rtl/nw_pkg.sv
// Shared definitions for the sequence loader: symbol codes, framing
// characters and the loader state encoding.
package nw_pkg;

    localparam int SYM_W = 3;

    localparam logic [SYM_W-1:0] SYM_A = 3'd1;
    localparam logic [SYM_W-1:0] SYM_C = 3'd2;
    localparam logic [SYM_W-1:0] SYM_G = 3'd3;
    localparam logic [SYM_W-1:0] SYM_T = 3'd4;

    localparam logic [7:0] CHR_SEP = 8'h23;
    localparam logic [7:0] CHR_EOL = 8'h0A;
    localparam logic [7:0] CHR_CR  = 8'h0D;
    localparam logic [7:0] CHR_SP  = 8'h20;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        DONE   = 2'd2
    } load_state_e;

endpackage

// File: rtl/seq_char_decode.sv
// Combinational classifier for one received byte: nucleotide (with its
// symbol code), sequence separator, end of line, or silently skipped.
// A byte that raises none of the flags is an invalid character.
module seq_char_decode
    import nw_pkg::*;
(
    input  logic [7:0]       data_i,
    output logic             is_sym_o,
    output logic             is_sep_o,
    output logic             is_eol_o,
    output logic             is_skip_o,
    output logic [SYM_W-1:0] code_o
);

    // Case-insensitive nucleotide lookup plus framing characters.
    always_comb begin
        is_sym_o  = 1'b0;
        is_sep_o  = 1'b0;
        is_eol_o  = 1'b0;
        is_skip_o = 1'b0;
        code_o    = '0;
        case (data_i)
            8'h41, 8'h61: begin is_sym_o = 1'b1; code_o = SYM_A; end
            8'h43, 8'h63: begin is_sym_o = 1'b1; code_o = SYM_C; end
            8'h47, 8'h67: begin is_sym_o = 1'b1; code_o = SYM_G; end
            8'h54, 8'h74: begin is_sym_o = 1'b1; code_o = SYM_T; end
            CHR_SEP:      is_sep_o  = 1'b1;
            CHR_EOL:      is_eol_o  = 1'b1;
            CHR_CR,
            CHR_SP:       is_skip_o = 1'b1;
            default:      ;
        endcase
    end

endmodule

// File: rtl/uart_seq_loader.sv
// Loads two ASCII nucleotide sequences from the UART byte stream into the
// NW sequence RAMs. Sequence A ends at '#', sequence B ends at LF. Every
// output is a flop; the write address of a RAM trails its length counter
// by one cycle, so during a write it shows the slot being written and
// afterwards the next free slot (held at the last slot once full).
module uart_seq_loader
    import nw_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int SYM_W  = nw_pkg::SYM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              clear,
    output logic [SYM_W-1:0]  Seq,
    output logic [ADDR_W-1:0] address_ramA,
    output logic [ADDR_W-1:0] address_ramB,
    output logic              weA,
    output logic              weB,
    output logic              enable_ram,
    output logic [ADDR_W:0]   lenA,
    output logic [ADDR_W:0]   lenB,
    output logic              load_done,
    output logic              error
);

    localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] One    = {{ADDR_W{1'b0}}, 1'b1};

    load_state_e       state_q, state_d;
    logic [ADDR_W:0]   lenA_q, lenA_d, lenB_q, lenB_d;
    logic [ADDR_W-1:0] addrA_q, addrA_d, addrB_q, addrB_d;
    logic              weA_q, weA_d, weB_q, weB_d;
    logic              en_q;
    logic [SYM_W-1:0]  seq_q, seq_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    logic                    isSym, isSep, isEol, isSkip;
    logic [nw_pkg::SYM_W-1:0] symCode;

    seq_char_decode u_decode (
        .data_i    (rx_data),
        .is_sym_o  (isSym),
        .is_sep_o  (isSep),
        .is_eol_o  (isEol),
        .is_skip_o (isSkip),
        .code_o    (symCode)
    );

    // Next free slot for a given length, held at the last slot when full.
    function automatic logic [ADDR_W-1:0] satAddr(input logic [ADDR_W:0] len);
        if (len[ADDR_W]) return {ADDR_W{1'b1}};
        return len[ADDR_W-1:0];
    endfunction

    // Next-state, counter and write-port decisions for one received byte.
    always_comb begin
        state_d = state_q;
        lenA_d  = lenA_q;
        lenB_d  = lenB_q;
        addrA_d = satAddr(lenA_q);
        addrB_d = satAddr(lenB_q);
        weA_d   = 1'b0;
        weB_d   = 1'b0;
        seq_d   = seq_q;
        err_d   = err_q;
        if (clear) begin
            state_d = LOAD_A;
            lenA_d  = '0;
            lenB_d  = '0;
            addrA_d = '0;
            addrB_d = '0;
            err_d   = 1'b0;
        end else if (rx_valid) begin
            case (state_q)
                LOAD_A: begin
                    if (isSym) begin
                        if (lenA_q < MaxLen) begin
                            weA_d  = 1'b1;
                            seq_d  = SYM_W'(symCode);
                            lenA_d = lenA_q + One;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (isSep) begin
                        state_d = LOAD_B;
                    end else if (!isSkip) begin
                        err_d = 1'b1;
                    end
                end
                LOAD_B: begin
                    if (isSym) begin
                        if (lenB_q < MaxLen) begin
                            weB_d  = 1'b1;
                            seq_d  = SYM_W'(symCode);
                            lenB_d = lenB_q + One;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (isEol) begin
                        state_d = DONE;
                    end else if (!isSkip) begin
                        err_d = 1'b1;
                    end
                end
                DONE: ;
                default: state_d = LOAD_A;
            endcase
        end
        done_d = (state_d == DONE);
    end

    // State, counters and the registered RAM write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOAD_A;
            lenA_q  <= '0;
            lenB_q  <= '0;
            addrA_q <= '0;
            addrB_q <= '0;
            weA_q   <= 1'b0;
            weB_q   <= 1'b0;
            en_q    <= 1'b0;
            seq_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lenA_q  <= lenA_d;
            lenB_q  <= lenB_d;
            addrA_q <= addrA_d;
            addrB_q <= addrB_d;
            weA_q   <= weA_d;
            weB_q   <= weB_d;
            en_q    <= weA_d | weB_d;
            seq_q   <= seq_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign Seq          = seq_q;
    assign address_ramA = addrA_q;
    assign address_ramB = addrB_q;
    assign weA          = weA_q;
    assign weB          = weB_q;
    assign enable_ram   = en_q;
    assign lenA         = lenA_q;
    assign lenB         = lenB_q;
    assign load_done    = done_q;
    assign error        = err_q;

endmodule

// File: tb/tb_uart_seq_loader.sv
// Testbench for uart_seq_loader: directed scenarios plus randomized byte
// streams, checked every cycle against a queue-based model of the loader.
module tb_uart_seq_loader;

    localparam int AW = 3;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          clear = 1'b0;
    logic [SW-1:0] Seq;
    logic [AW-1:0] address_ramA, address_ramB;
    logic          weA, weB, enable_ram;
    logic [AW:0]   lenA, lenB;
    logic          load_done, error;

    int compared   = 0;
    int mismatched = 0;

    // Model: stored symbols per sequence, phase 0=A,1=B,2=done.
    int qa[$];
    int qb[$];
    int mPhase   = 0;
    bit mErr     = 0;
    bit expWeA   = 0;
    bit expWeB   = 0;
    int expSeq   = 0;
    int expAddrA = 0;
    int expAddrB = 0;

    // Bench-side image of the RAMs, filled from observed write pulses.
    int ramA[8];
    int ramB[8];

    uart_seq_loader #(.ADDR_W(AW), .SYM_W(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .clear        (clear),
        .Seq          (Seq),
        .address_ramA (address_ramA),
        .address_ramB (address_ramB),
        .weA          (weA),
        .weB          (weB),
        .enable_ram   (enable_ram),
        .lenA         (lenA),
        .lenB         (lenB),
        .load_done    (load_done),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int symCode(input logic [7:0] b);
        case (b)
            "A", "a": return 1;
            "C", "c": return 2;
            "G", "g": return 3;
            "T", "t": return 4;
            default:  return 0;
        endcase
    endfunction

    function automatic int nextSlot(input int n);
        return (n > 7) ? 7 : n;
    endfunction

    task automatic modelReset();
        qa.delete();
        qb.delete();
        mPhase = 0;
        mErr   = 0;
        expWeA = 0;
        expWeB = 0;
        expAddrA = 0;
        expAddrB = 0;
    endtask

    // Effect of one cycle's inputs on the outputs seen after the next edge.
    task automatic modelStep(input logic [7:0] b, input bit v, input bit c);
        int code;
        expWeA = 0;
        expWeB = 0;
        if (c) begin
            qa.delete();
            qb.delete();
            mPhase = 0;
            mErr   = 0;
        end else if (v && mPhase != 2) begin
            code = symCode(b);
            if (code != 0) begin
                if (mPhase == 0) begin
                    if (qa.size() < 8) begin expWeA = 1; expSeq = code; qa.push_back(code); end
                    else mErr = 1;
                end else begin
                    if (qb.size() < 8) begin expWeB = 1; expSeq = code; qb.push_back(code); end
                    else mErr = 1;
                end
            end else if (b == 8'h23) begin
                if (mPhase == 0) mPhase = 1; else mErr = 1;
            end else if (b == 8'h0A) begin
                if (mPhase == 1) mPhase = 2; else mErr = 1;
            end else if (b != 8'h0D && b != 8'h20) begin
                mErr = 1;
            end
        end
        expAddrA = expWeA ? qa.size() - 1 : nextSlot(qa.size());
        expAddrB = expWeB ? qb.size() - 1 : nextSlot(qb.size());
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit v, input bit c);
        @(negedge clk);
        rx_data  = b;
        rx_valid = v;
        clear    = c;
        if (!rst) modelReset();
        else modelStep(b, v, c);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(8'h00, 1'b0, 1'b0);
    endtask

    task automatic sendString(input string s);
        for (int i = 0; i < s.len(); i++) applyStimulus(s[i], 1'b1, 1'b0);
    endtask

    task automatic doReset(input int n);
        @(negedge clk);
        rst = 1'b0;
        rx_valid = 1'b0;
        clear = 1'b0;
        modelReset();
        repeat (n) applyStimulus(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        modelStep(8'h00, 1'b0, 1'b0);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        #2;
        checkOutput("weA", weA, expWeA);
        checkOutput("weB", weB, expWeB);
        checkOutput("enable_ram", enable_ram, expWeA | expWeB);
        checkOutput("address_ramA", address_ramA, expAddrA);
        checkOutput("address_ramB", address_ramB, expAddrB);
        checkOutput("lenA", lenA, qa.size());
        checkOutput("lenB", lenB, qb.size());
        checkOutput("load_done", load_done, mPhase == 2);
        checkOutput("error", error, mErr);
        if (expWeA || expWeB) checkOutput("Seq", Seq, expSeq);
        if (weA === 1'b1) ramA[address_ramA] = Seq;
        if (weB === 1'b1) ramB[address_ramB] = Seq;
    end

    initial begin
        int r;
        logic [7:0] b;
        string syms;
        syms = "ACGTacgt";
        #1;
        rst = 1'b0;
        modelReset();
        repeat (10) applyStimulus(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        modelStep(8'h00, 1'b0, 1'b0);
        checkOutput("reset lenA", lenA, 0);
        checkOutput("reset load_done", load_done, 0);

        sendString("A#C\n");
        idle(2);
        checkOutput("t2 lenA", lenA, 1);
        checkOutput("t2 lenB", lenB, 1);
        checkOutput("t2 load_done", load_done, 1);
        checkOutput("t2 error", error, 0);
        checkOutput("t2 ramA0", ramA[0], 1);
        checkOutput("t2 ramB0", ramB[0], 2);
        applyStimulus(8'h00, 1'b0, 1'b1);

        sendString("acgt#TGCA\n");
        idle(2);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t3 ramA", ramA[i], i + 1);
            checkOutput("t3 ramB", ramB[i], 4 - i);
        end
        checkOutput("t3 lenA", lenA, 4);
        checkOutput("t3 lenB", lenB, 4);
        applyStimulus(8'h00, 1'b0, 1'b1);

        sendString("GGGGGGGGG#");
        idle(2);
        checkOutput("t4 lenA", lenA, 8);
        checkOutput("t4 error", error, 1);
        checkOutput("t4 addrA", address_ramA, 7);
        checkOutput("t4 load_done", load_done, 0);
        checkOutput("t4 ramA7", ramA[7], 3);
        applyStimulus(8'h00, 1'b0, 1'b1);

        sendString("AX#\r\n");
        idle(2);
        checkOutput("t5 error", error, 1);
        checkOutput("t5 load_done", load_done, 1);
        checkOutput("t5 lenA", lenA, 1);
        checkOutput("t5 lenB", lenB, 0);

        sendString("T");
        idle(2);
        checkOutput("t6 lenB", lenB, 0);
        applyStimulus("A", 1'b1, 1'b1);
        idle(1);
        checkOutput("t6 lenA", lenA, 0);
        checkOutput("t6 error", error, 0);
        checkOutput("t6 load_done", load_done, 0);
        sendString("C");
        idle(2);
        checkOutput("t6 ramA0", ramA[0], 2);
        checkOutput("t6 lenA after C", lenA, 1);

        sendString("ACG");
        doReset(3);
        checkOutput("midreset lenA", lenA, 0);

        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      b = syms[$urandom_range(0, 7)];
            else if (r < 68) b = 8'h23;
            else if (r < 76) b = 8'h0A;
            else if (r < 82) b = 8'h0D;
            else if (r < 86) b = 8'h20;
            else             b = 8'($urandom_range(0, 255));
            applyStimulus(b, ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 63) == 0) || (mPhase == 2 && $urandom_range(0, 7) == 0));
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
